// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcode, funct3, ALU_OP, next-PC select and immediate format encodings
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    PCS_SEQ  = 2'b00,
    PCS_REL  = 2'b01,
    PCS_JALR = 2'b10,
    PCS_HOLD = 2'b11
  } pcs_t;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate extraction for I/S/B/U/J instruction formats
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] ir,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_U:   imm = {ir[31:12], 12'b0};
      FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - multi-cycle RV32I front end: PC/PC0/IR registers, next-PC mux and decode
module fetch_decode_unit
  import rv32i_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PC_Write,
  input  logic            PC0_Write,
  input  logic            IR_Write,
  input  logic [1:0]      PC_s,
  input  logic [XLEN-1:0] jalr_base,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc0_o,
  output logic            IS_R,
  output logic            IS_IMM,
  output logic            IS_LUI,
  output logic            IS_LW,
  output logic            IS_SW,
  output logic            IS_JAL,
  output logic            IS_JALR,
  output logic            IS_BEQ,
  output logic [3:0]      ALU_OP,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [31:0]     imm,
  output logic            ill_inst,
  output logic            misalign,
  output logic [31:0]     fetch_cnt
);

  logic [XLEN-1:0] pc, pc0, target, pc_next;
  logic [31:0]     ir;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            legal, mis_hit, ir_loaded;
  imm_fmt_t        fmt;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];

  assign IS_R    = (opcode == OP_R);
  assign IS_IMM  = (opcode == OP_IMM);
  assign IS_LUI  = (opcode == OP_LUI);
  assign IS_LW   = (opcode == OP_LOAD)   && (f3 == F3_LW);
  assign IS_SW   = (opcode == OP_STORE)  && (f3 == F3_SW);
  assign IS_JAL  = (opcode == OP_JAL);
  assign IS_JALR = (opcode == OP_JALR)   && (f3 == F3_JALR);
  assign IS_BEQ  = (opcode == OP_BRANCH) && (f3 == F3_BEQ);
  assign legal   = IS_R | IS_IMM | IS_LUI | IS_LW | IS_SW | IS_JAL | IS_JALR | IS_BEQ;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  always_comb begin
    ALU_OP = ALU_ADD;
    fmt    = FMT_NONE;
    if (IS_R) ALU_OP = {ir[30], f3};
    // Only the shift-right funct3 uses bit 30 as an op selector for immediates
    if (IS_IMM) ALU_OP = {(f3 == F3_SR) ? ir[30] : 1'b0, f3};
    if (IS_IMM || IS_LW || IS_JALR) fmt = FMT_I;
    if (IS_SW)  fmt = FMT_S;
    if (IS_BEQ) fmt = FMT_B;
    if (IS_LUI) fmt = FMT_U;
    if (IS_JAL) fmt = FMT_J;
  end

  imm_gen u_imm_gen (
    .ir  (ir[31:7]),
    .fmt (fmt),
    .imm (imm)
  );

  always_comb begin
    target = pc;
    case (PC_s)
      PCS_SEQ:  target = pc + XLEN'(4);
      PCS_REL:  target = pc0 + imm;
      PCS_JALR: target = jalr_base & ~XLEN'(1);
      default:  target = pc;
    endcase
    mis_hit = PC_Write && (PC_s != PCS_HOLD) && (target[1:0] != 2'b00);
    pc_next = PC_Write ? {target[XLEN-1:2], 2'b00} : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc0       <= '0;
      ir        <= NOP_INST;
      ill_inst  <= 1'b0;
      misalign  <= 1'b0;
      fetch_cnt <= '0;
      ir_loaded <= 1'b0;
    end else begin
      pc        <= pc_next;
      fetch_cnt <= fetch_cnt + 32'(IR_Write);
      ir_loaded <= IR_Write;
      if (PC0_Write) pc0 <= pc;
      if (IR_Write) ir <= imem_rdata;
      // The word loaded last edge is now in IR and decoded
      if (ir_loaded && !legal) ill_inst <= 1'b1;
      if (mis_hit) misalign <= 1'b1;
    end
  end

  assign imem_addr = pc;
  assign pc_o      = pc;
  assign pc0_o     = pc0;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - self-checking bench for fetch_decode_unit
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_Write, PC0_Write, IR_Write;
  logic [1:0]  PC_s;
  logic [31:0] jalr_base, imem_rdata, imem_addr, pc_o, pc0_o, imm, fetch_cnt;
  logic        IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_JAL, IS_JALR, IS_BEQ;
  logic [3:0]  ALU_OP;
  logic [4:0]  rs1, rs2, rd;
  logic        ill_inst, misalign;

  always #5 clk = ~clk;

  fetch_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .PC_Write(PC_Write), .PC0_Write(PC0_Write), .IR_Write(IR_Write),
    .PC_s(PC_s), .jalr_base(jalr_base), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .pc_o(pc_o), .pc0_o(pc0_o), .IS_R(IS_R), .IS_IMM(IS_IMM), .IS_LUI(IS_LUI), .IS_LW(IS_LW),
    .IS_SW(IS_SW), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR), .IS_BEQ(IS_BEQ), .ALU_OP(ALU_OP),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .ill_inst(ill_inst), .misalign(misalign),
    .fetch_cnt(fetch_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_pc, m_pc0, m_ir, m_cnt;
  logic        m_ill, m_mis, m_pend;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  flags;
    logic [3:0]  alu;
    logic [31:0] imm;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [7:0] dut_flags();
    return {IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_JAL, IS_JALR, IS_BEQ};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: class from opcode/funct3, immediate from weighted instruction fields
  task automatic mdecode(input logic [31:0] w, output logic [7:0] fl, output logic [3:0] alu,
                         output logic [31:0] im);
    logic [2:0]  f3;
    logic [31:0] i_imm;
    f3    = w[14:12];
    i_imm = 32'($signed(w) >>> 20);
    fl = 8'h00; alu = 4'h0; im = 32'h0;
    case (w[6:0])
      7'h33: begin fl = 8'h80; alu = 4'(f3) + (w[30] ? 4'd8 : 4'd0); end
      7'h13: begin fl = 8'h40; im = i_imm;
                   alu = 4'(f3) + ((f3 == 3'd5 && w[30]) ? 4'd8 : 4'd0); end
      7'h37: begin fl = 8'h20; im = w & 32'hFFFF_F000; end
      7'h03: if (f3 == 3'd2) begin fl = 8'h10; im = i_imm; end
      7'h23: if (f3 == 3'd2) begin fl = 8'h08;
               im = 32'($signed(w) >>> 25) * 32 + 32'(w[11:7]); end
      7'h6F: begin fl = 8'h04;
               im = (w[31] ? 32'hFFF0_0000 : 32'h0) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048
                    + 32'(w[30:21]) * 2; end
      7'h67: if (f3 == 3'd0) begin fl = 8'h02; im = i_imm; end
      7'h63: if (f3 == 3'd0) begin fl = 8'h01;
               im = (w[31] ? 32'hFFFF_F000 : 32'h0) + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32
                    + 32'(w[11:8]) * 2; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc0 = 32'h0; m_ir = 32'h13; m_cnt = 32'h0;
    m_ill = 1'b0; m_mis = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_clock();
    logic [7:0]  fl;
    logic [3:0]  alu;
    logic [31:0] im, tgt, npc;
    mdecode(m_ir, fl, alu, im);
    npc = m_pc;
    if (PC_Write && PC_s != 2'd3) begin
      case (PC_s)
        2'd0:    tgt = m_pc + 32'd4;
        2'd1:    tgt = m_pc0 + im;
        default: tgt = jalr_base - (jalr_base % 32'd2);
      endcase
      if (tgt % 32'd4 != 0) m_mis = 1'b1;
      npc = tgt - (tgt % 32'd4);
    end
    if (m_pend && fl == 8'h00) m_ill = 1'b1;
    m_pend = IR_Write;
    if (PC0_Write) m_pc0 = m_pc;
    if (IR_Write) begin m_ir = imem_rdata; m_cnt = m_cnt + 1; end
    m_pc = npc;
  endtask

  task automatic cmp_all();
    logic [7:0]  fl;
    logic [3:0]  alu;
    logic [31:0] im;
    mdecode(m_ir, fl, alu, im);
    chk("pc", pc_o, m_pc);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc0", pc0_o, m_pc0);
    chk("flags", 32'(dut_flags()), 32'(fl));
    chk("alu_op", 32'(ALU_OP), 32'(alu));
    chk("rs1", 32'(rs1), (m_ir >> 15) & 32'h1F);
    chk("rs2", 32'(rs2), (m_ir >> 20) & 32'h1F);
    chk("rd", 32'(rd), (m_ir >> 7) & 32'h1F);
    chk("imm", imm, im);
    chk("ill_inst", 32'(ill_inst), 32'(m_ill));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  task automatic drive(input logic pw, input logic p0w, input logic irw, input logic [1:0] pcs,
                       input logic [31:0] jb, input logic [31:0] word);
    PC_Write = pw; PC0_Write = p0w; IR_Write = irw; PC_s = pcs; jalr_base = jb; imem_rdata = word;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    cmp_all();
  endtask

  initial begin
    tbl[0]  = '{32'h0050_0093, 8'h40, 4'h0, 32'h0000_0005};
    tbl[1]  = '{32'h0020_81B3, 8'h80, 4'h0, 32'h0000_0000};
    tbl[2]  = '{32'h4020_81B3, 8'h80, 4'h8, 32'h0000_0000};
    tbl[3]  = '{32'h4030_D093, 8'h40, 4'hD, 32'h0000_0403};
    tbl[4]  = '{32'hFFF0_0093, 8'h40, 4'h0, 32'hFFFF_FFFF};
    tbl[5]  = '{32'h1234_52B7, 8'h20, 4'h0, 32'h1234_5000};
    tbl[6]  = '{32'h0081_2303, 8'h10, 4'h0, 32'h0000_0008};
    tbl[7]  = '{32'hFE61_2E23, 8'h08, 4'h0, 32'hFFFF_FFFC};
    tbl[8]  = '{32'h0080_006F, 8'h04, 4'h0, 32'h0000_0008};
    tbl[9]  = '{32'h0042_80E7, 8'h02, 4'h0, 32'h0000_0004};
    tbl[10] = '{32'hFE00_0EE3, 8'h01, 4'h0, 32'hFFFF_FFFC};
    tbl[11] = '{32'h0001_0303, 8'h00, 4'h0, 32'h0000_0000};
    tbl[12] = '{32'hFFFF_FFFF, 8'h00, 4'h0, 32'h0000_0000};
    tbl[13] = '{32'h0000_1063, 8'h00, 4'h0, 32'h0000_0000};
    tbl[14] = '{32'h0000_10E7, 8'h00, 4'h0, 32'h0000_0000};

    rst_n = 1'b0;
    drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_all();
    chk("reset_flags", 32'(dut_flags()), 32'h40);

    // Fetch addi x1,x0,5 at PC 0
    drive(1, 1, 1, 2'd0, 32'h0, 32'h0050_0093);
    step();
    drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
    chk("fetch_pc", pc_o, 32'h4);
    chk("fetch_pc0", pc0_o, 32'h0);
    chk("fetch_is_imm", 32'(IS_IMM), 32'h1);
    chk("fetch_rd", 32'(rd), 32'h1);
    chk("fetch_imm", imm, 32'h5);
    chk("fetch_alu", 32'(ALU_OP), 32'h0);
    chk("fetch_cnt", fetch_cnt, 32'h1);

    // JAL +8 from PC0=0x10
    drive(1, 0, 0, 2'd2, 32'h10, 32'h0); step();
    drive(1, 1, 1, 2'd0, 32'h0, 32'h0080_006F); step();
    drive(1, 0, 0, 2'd1, 32'h0, 32'h0); step();
    chk("jal_pc", pc_o, 32'h18);
    chk("jal_flag", 32'(IS_JAL), 32'h1);
    chk("jal_imm", imm, 32'h8);

    // BEQ -4 from PC0=0x20, first without PC_Write
    drive(1, 0, 0, 2'd2, 32'h20, 32'h0); step();
    drive(1, 1, 1, 2'd0, 32'h0, 32'hFE00_0EE3); step();
    drive(0, 0, 0, 2'd1, 32'h0, 32'h0); step();
    chk("beq_nowrite_pc", pc_o, 32'h24);
    drive(1, 0, 0, 2'd1, 32'h0, 32'h0); step();
    chk("beq_pc", pc_o, 32'h1C);

    // JALR bit-0 clear and misalignment stickiness
    drive(1, 0, 0, 2'd2, 32'h101, 32'h0); step();
    chk("jalr_pc", pc_o, 32'h100);
    chk("jalr_mis0", 32'(misalign), 32'h0);
    drive(1, 0, 0, 2'd2, 32'h103, 32'h0); step();
    chk("jalr_mis_pc", pc_o, 32'h100);
    chk("jalr_mis1", 32'(misalign), 32'h1);
    drive(1, 0, 0, 2'd2, 32'h200, 32'h0); step();
    chk("mis_sticky", 32'(misalign), 32'h1);

    // Illegal word and PC hold
    drive(0, 0, 1, 2'd0, 32'h0, 32'hFFFF_FFFF); step();
    drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
    chk("ill_flags", 32'(dut_flags()), 32'h0);
    step();
    chk("ill_set", 32'(ill_inst), 32'h1);
    drive(1, 0, 0, 2'd3, 32'h0, 32'h0); step();
    chk("hold_pc", pc_o, 32'h200);

    // PC+4 wraps at 2^32
    drive(1, 0, 0, 2'd2, 32'hFFFF_FFFC, 32'h0); step();
    drive(1, 0, 0, 2'd0, 32'h0, 32'h0); step();
    chk("wrap_pc", pc_o, 32'h0);

    for (int i = 0; i < 15; i++) begin
      drive(1, 1, 1, 2'd0, 32'h0, tbl[i].instr);
      step();
      drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
      chk("tbl_flags", 32'(dut_flags()), 32'(tbl[i].flags));
      chk("tbl_alu", 32'(ALU_OP), 32'(tbl[i].alu));
      chk("tbl_imm", imm, tbl[i].imm);
      step();
    end

    repeat (400) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) ? tbl[$urandom_range(0, 14)].instr : $urandom);
      step();
    end

    // Asynchronous reset mid-cycle with PC=0x40, strobes left active
    drive(1, 1, 1, 2'd2, 32'h40, 32'h0020_81B3); step();
    chk("pre_reset_pc", pc_o, 32'h40);
    chk("pre_reset_ill", 32'(ill_inst), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all();
    chk("areset_pc", pc_o, 32'h0);
    chk("areset_flags", 32'(dut_flags()), 32'h40);
    chk("areset_imm", imm, 32'h0);
    chk("areset_cnt", fetch_cnt, 32'h0);
    chk("areset_ill", 32'(ill_inst), 32'h0);
    chk("areset_mis", 32'(misalign), 32'h0);
    @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;
    step();
    chk("release_pc", pc_o, 32'h40);
    chk("release_cnt", fetch_cnt, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
